// File: rtl/link_frame_sequencer.sv
// Frame sequencer: serialises one frame LSB-first into SYM_W-bit symbols, reassembles
// the symbols returning after CH_LAT cycles and counts bit errors against the sent copy.
module link_frame_sequencer #(
    parameter int FRAME_W = 28,
    parameter int SYM_W   = 2,
    parameter int CH_LAT  = 2,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FRAME_W-1:0]             frame_i,
    input  logic                           frame_valid_i,
    output logic                           frame_ready_o,
    output logic [SYM_W-1:0]               sym_o,
    output logic                           sym_valid_o,
    input  logic [SYM_W-1:0]               sym_i,
    input  logic                           clear_i,
    output logic [FRAME_W-1:0]             frame_o,
    output logic                           frame_valid_o,
    output logic [$clog2(FRAME_W+1)-1:0]   err_bits_o,
    output logic [CNT_W-1:0]               err_total_o,
    output logic [CNT_W-1:0]               frame_cnt_o,
    output logic                           busy_o
);

    localparam int NSYM = FRAME_W / SYM_W;
    localparam int IW   = $clog2(NSYM + 1);
    localparam int EW   = $clog2(FRAME_W + 1);
    localparam int SW   = ((CNT_W > EW) ? CNT_W : EW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, TX, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] tx_buf_q, tx_buf_d;
    logic [FRAME_W-1:0] tx_shift_q, tx_shift_d;
    logic [IW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [CH_LAT-1:0]  vdly_q, vdly_d;
    logic [FRAME_W-1:0] rx_buf_q, rx_buf_d, rx_next;
    logic [IW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [EW-1:0]      err_bits_q, err_bits_d;
    logic [CNT_W-1:0]   err_total_q, err_total_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               fvalid_q, fvalid_d;
    logic               ready_q;
    logic               accept, rx_cap, rx_last;
    logic [SW-1:0]      sum;

    function automatic logic [EW-1:0] popcount(input logic [FRAME_W-1:0] v);
        logic [EW-1:0] c;
        c = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            c = c + EW'(v[i]);
        end
        return c;
    endfunction

    assign accept  = frame_valid_i && ready_q;
    assign rx_cap  = vdly_q[CH_LAT-1];
    assign rx_last = rx_cap && (rx_cnt_q == IW'(NSYM - 1));
    // Returning symbols enter at the top so symbol 0 ends up in the low bits.
    assign rx_next = (rx_buf_q >> SYM_W) | (FRAME_W'(sym_i) << (FRAME_W - SYM_W));

    always_comb begin
        state_d    = state_q;
        tx_buf_d   = tx_buf_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_buf_d   = frame_i;
                    tx_shift_d = frame_i;
                    tx_cnt_d   = '0;
                    state_d    = TX;
                end
            end
            TX: begin
                tx_shift_d = tx_shift_q >> SYM_W;
                if (tx_cnt_q == IW'(NSYM - 1)) begin
                    tx_cnt_d = '0;
                    state_d  = DRAIN;
                end else begin
                    tx_cnt_d = tx_cnt_q + IW'(1);
                end
            end
            DRAIN: begin
                if (rx_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture and completion bookkeeping; clear_i overrides a coincident completion.
    always_comb begin
        vdly_d      = (vdly_q << 1) | CH_LAT'(sym_valid_o);
        rx_buf_d    = rx_buf_q;
        rx_cnt_d    = rx_cnt_q;
        frame_d     = frame_q;
        err_bits_d  = err_bits_q;
        err_total_d = err_total_q;
        frame_cnt_d = frame_cnt_q;
        fvalid_d    = 1'b0;
        sum         = '0;
        if (rx_cap) begin
            rx_buf_d = rx_next;
            rx_cnt_d = rx_cnt_q + IW'(1);
        end
        if (rx_last) begin
            rx_cnt_d    = '0;
            frame_d     = rx_next;
            err_bits_d  = popcount(rx_next ^ tx_buf_q);
            fvalid_d    = 1'b1;
            sum         = SW'(err_total_q) + SW'(err_bits_d);
            err_total_d = (sum > {{(SW-CNT_W){1'b0}}, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (clear_i) begin
            err_total_d = '0;
            frame_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_buf_q    <= '0;
            tx_shift_q  <= '0;
            tx_cnt_q    <= '0;
            vdly_q      <= '0;
            rx_buf_q    <= '0;
            rx_cnt_q    <= '0;
            frame_q     <= '0;
            err_bits_q  <= '0;
            err_total_q <= '0;
            frame_cnt_q <= '0;
            fvalid_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_buf_q    <= tx_buf_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            vdly_q      <= vdly_d;
            rx_buf_q    <= rx_buf_d;
            rx_cnt_q    <= rx_cnt_d;
            frame_q     <= frame_d;
            err_bits_q  <= err_bits_d;
            err_total_q <= err_total_d;
            frame_cnt_q <= frame_cnt_d;
            fvalid_q    <= fvalid_d;
            ready_q     <= (state_d == IDLE);
        end
    end

    assign frame_ready_o = ready_q;
    assign sym_o         = tx_shift_q[SYM_W-1:0];
    assign sym_valid_o   = (state_q == TX);
    assign frame_o       = frame_q;
    assign frame_valid_o = fvalid_q;
    assign err_bits_o    = err_bits_q;
    assign err_total_o   = err_total_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign busy_o        = (state_q != IDLE);

endmodule
